// File: rtl/ssegment_scan.sv
// Time-multiplexed seven-segment scan driver: one BCD nibble and one digit enable per slot,
// with a blank guard interval, frame-boundary commit of loaded values and leading-zero blanking.
module ssegment_scan #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int GUARD    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  lz_blank,
    output logic [3:0]            data,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(PRESCALE - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);

    typedef enum logic {
        ST_GUARD,
        ST_SHOW
    } state_t;

    state_t              state, state_n;
    logic [TW-1:0]       tick, tick_n;
    logic [IW-1:0]       idx, idx_n;
    logic [4*DIGITS-1:0] shadow, active;
    logic                slot_end, commit;
    logic [DIGITS-1:0]   lead_zero;
    logic                run_zero;
    logic [3:0]          nibble, data_n;
    logic [DIGITS-1:0]   en_n;

    always_comb begin
        slot_end = (tick == LAST_TICK);
        commit   = slot_end && (idx == LAST_IDX);
        tick_n   = slot_end ? '0 : tick + TW'(1);
        idx_n    = idx;
        if (slot_end) begin
            idx_n = (idx == LAST_IDX) ? '0 : idx + IW'(1);
        end
        state_n = (int'(tick_n) < GUARD) ? ST_GUARD : ST_SHOW;
    end

    // lead_zero[i] is set when nibbles i..DIGITS-1 of the active value are all zero
    always_comb begin
        lead_zero = '0;
        run_zero  = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            run_zero = run_zero && (active[4*(DIGITS-1-k) +: 4] == 4'h0);
            lead_zero[DIGITS-1-k] = run_zero;
        end
    end

    always_comb begin
        nibble = active[{idx, 2'b00} +: 4];
        if (lz_blank && (idx != '0) && lead_zero[idx]) begin
            nibble = 4'hF;
        end
        data_n = 4'hF;
        en_n   = '0;
        if (state == ST_SHOW) begin
            data_n = nibble;
            en_n   = DIGITS'(1) << idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick       <= '0;
            idx        <= '0;
            // tick 0 already belongs to the visible phase when there is no guard interval
            state      <= (GUARD == 0) ? ST_SHOW : ST_GUARD;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            data       <= 4'hF;
            digit_en   <= '0;
        end else begin
            tick       <= tick_n;
            idx        <= idx_n;
            state      <= state_n;
            data       <= data_n;
            digit_en   <= en_n;
            frame_done <= commit;
            if (load) begin
                shadow <= value;
            end
            // a load on the commit cycle bypasses the shadow and goes live immediately
            if (commit) begin
                if (load || pending) begin
                    active <= load ? value : shadow;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ssegment_scan.sv
// Scoreboard bench for ssegment_scan: a cycle-count reference model queues expected outputs,
// and a monitor on the falling edge compares them with the DUT.
module tb_ssegment_scan;

    localparam int D = 4;
    localparam int P = 8;
    localparam int G = 2;
    localparam int FRAME = D * P;

    logic          clk;
    logic          rst;
    logic          load;
    logic [15:0]   value;
    logic          lz_blank;
    logic [3:0]    data;
    logic [3:0]    digit_en;
    logic          pending;
    logic          frame_done;

    ssegment_scan #(.DIGITS(D), .PRESCALE(P), .GUARD(G)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .lz_blank   (lz_blank),
        .data       (data),
        .digit_en   (digit_en),
        .pending    (pending),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [3:0] data;
        logic [3:0] en;
        logic       pend;
        logic       fd;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          started = 0;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_active = '0;
    bit          m_pending = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, want);
        end
    endtask

    // Displayed nibble for digit d: leading zeros are those where active >> 4d is zero
    function automatic logic [3:0] shown(input logic [15:0] act, input int d, input logic lz);
        logic [15:0] upper;
        upper = act >> (4 * d);
        if (lz && d > 0 && upper == 16'h0) return 4'hF;
        return upper[3:0];
    endfunction

    // Reference model: position in the scan is derived from cycles elapsed since reset
    initial begin
        exp_t e;
        int t, d;
        bit last;
        forever begin
            @(posedge clk);
            if (rst) begin
                e = '{data: 4'hF, en: 4'h0, pend: 1'b0, fd: 1'b0};
                expq.push_back(e);
                cyc = 0; m_shadow = '0; m_active = '0; m_pending = 0; started = 1;
            end else if (started) begin
                t = cyc % P;
                d = (cyc / P) % D;
                e.data = (t < G) ? 4'hF : shown(m_active, d, lz_blank);
                e.en   = (t < G) ? 4'h0 : 4'(1 << d);
                last   = (t == P - 1) && (d == D - 1);
                e.fd   = last;
                if (last) begin
                    if (load) m_active = value;
                    else if (m_pending) m_active = m_shadow;
                    m_pending = 0;
                end else if (load) begin
                    m_pending = 1;
                end
                if (load) m_shadow = value;
                e.pend = m_pending;
                expq.push_back(e);
                cyc++;
            end
        end
    end

    // Monitor: one expected entry per clock edge, compared half a cycle later
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("data", data, e.data);
                check("digit_en", digit_en, e.en);
                check("pending", {3'b0, pending}, {3'b0, e.pend});
                check("frame_done", {3'b0, frame_done}, {3'b0, e.fd});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; value = v;
        step(1);
        load = 1'b0;
    endtask

    // Advance until the next edge will be at frame position target (bounded)
    task automatic wait_phase(input int target);
        int n;
        n = 0;
        while ((cyc % FRAME) != target && n < 2 * FRAME) begin
            step(1);
            n++;
        end
        if ((cyc % FRAME) != target) begin
            checks++; errors++;
            $display("FAIL wait_phase: got position %0d expected %0d", cyc % FRAME, target);
        end
    endtask

    initial begin
        logic [15:0] v;
        rst = 1'b1; load = 1'b0; value = '0; lz_blank = 1'b0;
        step(2);
        rst = 1'b0;
        step(70);

        wait_phase(10);
        do_load(16'h1234);
        step(80);

        lz_blank = 1'b1;
        do_load(16'h0070);
        step(70);
        do_load(16'h0000);
        step(70);
        lz_blank = 1'b0;

        wait_phase(5);
        do_load(16'h1111);
        wait_phase(FRAME - 1);
        do_load(16'h9999);
        step(40);

        wait_phase(3);
        do_load(16'h1111);
        step(6);
        do_load(16'h2222);
        step(70);

        wait_phase(2);
        do_load(16'h4321);
        wait_phase(2 * P + 4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(40);

        lz_blank = 1'b1;
        do_load(16'h00A5);
        step(70);

        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                v = 16'($urandom);
                case ($urandom_range(0, 4))
                    0: v = v & 16'h00FF;
                    1: v = v & 16'h000F;
                    2: v = 16'h0000;
                    3: v = v & 16'h0F0F;
                    default: ;
                endcase
                load = 1'b1; value = v;
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 31) == 0) lz_blank = ~lz_blank;
            rst = ($urandom_range(0, 299) == 0);
            step(1);
        end
        load = 1'b0; rst = 1'b0;
        step(3);
        @(negedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d entries expected 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ssegment_scan.md
Name: ssegment_scan

Overview:
- Time-multiplexed scan driver for a common-anode/cathode bank of DIGITS seven-segment digits.
- Sits directly upstream of the BCD-to-segment decoder. It presents one BCD nibble per scan slot on data, which feeds the decoder's 4-bit input, and drives the matching digit enable.
- Provides tear-free value updates at frame boundaries, a guard (blank) interval between slots to prevent ghosting, and optional leading-zero blanking.

Parameters:
- DIGITS, 4, number of digits scanned; must be ≥1.
- PRESCALE, 50000, clk cycles per digit slot; must be ≥2.
- GUARD, 16, blank cycles at the start of each slot; 0 ≤ GUARD < PRESCALE.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  capture value into the shadow register this cycle.
- value  in  4*DIGITS  packed BCD; nibble i is digit i, and digit 0 is least significant (rightmost).
- lz_blank  in  1  enable leading-zero blanking.
- data  out  4  nibble to the decoder; 4'hF means blank, since the decoder outputs all segments off for codes >9.
- digit_en  out  DIGITS  one-hot active-high digit enable, or all zero.
- pending  out  1  shadow value is waiting for a frame-boundary commit.
- frame_done  out  1  one-cycle pulse marking the start of each new frame.

Behaviour:
- All outputs are registered.
- Reset (clk edge with rst=1) sets:
  - data=4'hF, digit_en=0, pending=0, frame_done=0.
  - shadow=0, active=0, digit index=0, tick counter=0, state=GUARD.
- Reset mid-slot or mid-frame aborts immediately. A pending load is discarded.
- Tick counter runs 0..PRESCALE-1 within each slot, then wraps to 0 and advances the digit index (DIGITS-1 wraps to 0).
- Two states:
  - GUARD: ticks 0..GUARD-1. digit_en=0, data=4'hF.
  - SHOW: ticks GUARD..PRESCALE-1. digit_en=one-hot(index), data=displayed nibble of active[index].
  - With GUARD=0, GUARD is never entered.
  - Transition GUARD→SHOW at tick GUARD; SHOW→GUARD at the slot wrap.
- Output timing: data and digit_en reflect state/index with exactly 1 clk of latency (registered from the current counter values).
- Load handshake:
  - Any cycle with load=1 sets shadow<=value and pending<=1.
  - No back-pressure exists; back-to-back loads overwrite, last one wins.
- Commit happens on the final cycle of digit DIGITS-1's slot (tick=PRESCALE-1, index=DIGITS-1):
  - active <= (load ? value : shadow).
  - pending <= 0, including when load=1 that same cycle, because the value was bypassed straight into active.
  - If pending=0 and load=0, active is unchanged.
- frame_done=1 for exactly the one cycle after commit, aligned with the first tick of digit 0's slot. It pulses every frame whether or not anything was committed.
- Leading-zero blanking:
  - If lz_blank=1, digit i (i≥1) shows 4'hF when active nibbles i..DIGITS-1 are all 4'h0.
  - Digit 0 is never LZ-blanked.
  - lz_blank is sampled live, not frame-latched.
- Non-BCD nibbles (A–F) pass through unchanged; the decoder blanks them. They count as non-zero for LZ purposes.
- Frame period is DIGITS*PRESCALE clk. The duty per digit is (PRESCALE-GUARD)/(DIGITS*PRESCALE).

Test Plan:
- Use DIGITS=4, PRESCALE=8, GUARD=2.
- Reset then idle:
  - data=F and digit_en=0 for 2 clk after reset.
  - Then digit_en=0001 with data=0 for 6 clk; then 2 blank clk; then digit_en=0010 with data=0 (lz_blank=0).
  - frame_done pulses every 32 clk.
- Load 16'h1234 mid-frame:
  - pending=1 and the display keeps showing 0000 until the boundary.
  - Next frame shows 4,3,2,1 on enables 0001,0010,0100,1000, and pending=0.
- Load 16'h0070 with lz_blank=1:
  - digits 0 and 1 show 0 and 7; digits 2 and 3 show data=F.
  - With 16'h0000, only digit 0 shows 0.
- Load asserted exactly on the commit cycle with value 16'h9999, shadow holding 16'h1111:
  - next frame shows 9999 and pending=0.
  - Separately, load 16'h1111 then 16'h2222 within one frame: 2222 is displayed.
- Assert rst in the SHOW phase of digit 2 with pending=1:
  - next cycle data=F, digit_en=0, pending=0.
  - Scan restarts at digit 0 and the display shows 0000.
- Load 16'h00A5 with lz_blank=1:
  - digit 1 data=A (not blanked) and digit 0 data=5; digits 2 and 3 show F.
